// File: rtl/divclk_monitor.sv
// -----------------------------------------------------------------------------
// divclk_monitor
// Receive-side health checker for a locally divided clock. The divided clock
// is sampled as data in the i_clk domain; the monitor measures its period and
// high time in i_clk cycles, compares them with the expected divide ratio and
// reports per-measurement results, lock status and loss of clock.
//
// Ports
//   i_clk         system clock
//   i_rst_n       asynchronous, active-low reset
//   i_div_clk     divided clock under test (sampled as data)
//   o_period      last measured period, in i_clk cycles
//   o_high        last measured high time, in i_clk cycles
//   o_meas_valid  one-cycle pulse: o_period/o_high updated this cycle
//   o_err         one-cycle pulse with o_meas_valid: measurement mismatched
//   o_stall       one-cycle pulse: no rising edge within P_TIMEOUT cycles
//   o_locked      level: P_LOCK_CNT consecutive matches, no error/stall since
// -----------------------------------------------------------------------------
module divclk_monitor #(
    parameter int P_SYNC       = 0,
    parameter int P_CNT_W      = 8,
    parameter int P_EXP_PERIOD = 4,
    parameter int P_EXP_HIGH   = 2,
    parameter int P_LOCK_CNT   = 4,
    parameter int P_TIMEOUT    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_div_clk,
    output logic [P_CNT_W-1:0] o_period,
    output logic [P_CNT_W-1:0] o_high,
    output logic               o_meas_valid,
    output logic               o_err,
    output logic               o_stall,
    output logic               o_locked
);

    localparam logic [P_CNT_W-1:0] CNT_ZERO   = {P_CNT_W{1'b0}};
    localparam logic [P_CNT_W-1:0] CNT_ONE    = {{(P_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [P_CNT_W-1:0] CNT_MAX    = {P_CNT_W{1'b1}};
    localparam logic [P_CNT_W-1:0] EXP_PERIOD = P_CNT_W'(P_EXP_PERIOD);
    localparam logic [P_CNT_W-1:0] EXP_HIGH   = P_CNT_W'(P_EXP_HIGH);
    localparam logic [P_CNT_W-1:0] TIMEOUT    = P_CNT_W'(P_TIMEOUT);
    localparam logic [3:0]         LOCK_TGT   = 4'(P_LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEAS   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    logic               samp_s;
    logic               samp_d_r;
    logic               rise_s;
    logic [P_CNT_W-1:0] cnt_r;
    logic [P_CNT_W-1:0] hcnt_r;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         mcnt_r;
    logic [3:0]         mcnt_nxt_s;
    logic [3:0]         mcnt_inc_s;
    logic               match_s;

    logic [P_CNT_W-1:0] period_r;
    logic [P_CNT_W-1:0] period_nxt_s;
    logic [P_CNT_W-1:0] high_r;
    logic [P_CNT_W-1:0] high_nxt_s;
    logic               valid_r;
    logic               valid_nxt_s;
    logic               err_r;
    logic               err_nxt_s;
    logic               stall_r;
    logic               stall_nxt_s;
    logic               locked_r;
    logic               locked_nxt_s;

    // The divided clock is asynchronous data when P_SYNC=1, so it gets a
    // 2-flop synchronizer in front of the sample register.
    generate
        if (P_SYNC != 0) begin : g_sync
            logic [2:0] sync_r;

            // Synchronizer chain plus sample register.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    sync_r <= 3'b000;
                end else begin
                    sync_r <= {sync_r[1:0], i_div_clk};
                end
            end

            assign samp_s = sync_r[2];
        end else begin : g_direct
            logic samp_r;

            // Single sample register for a divider that shares i_clk.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    samp_r <= 1'b0;
                end else begin
                    samp_r <= i_div_clk;
                end
            end

            assign samp_s = samp_r;
        end
    endgenerate

    // Delayed copy of the sample for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            samp_d_r <= 1'b0;
        end else begin
            samp_d_r <= samp_s;
        end
    end

    assign rise_s = samp_s & ~samp_d_r;

    // Period and high-time counters; both restart on every rising edge so
    // that their value in a rise cycle is the measurement of the last period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r  <= CNT_ZERO;
            hcnt_r <= CNT_ZERO;
        end else begin
            if (rise_s) begin
                cnt_r <= CNT_ONE;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end

            if (rise_s) begin
                hcnt_r <= samp_s ? CNT_ONE : CNT_ZERO;
            end else if (samp_s && (hcnt_r != CNT_MAX)) begin
                hcnt_r <= hcnt_r + CNT_ONE;
            end else begin
                hcnt_r <= hcnt_r;
            end
        end
    end

    assign match_s    = (cnt_r == EXP_PERIOD) && (hcnt_r == EXP_HIGH);
    assign mcnt_inc_s = (mcnt_r == 4'hF) ? mcnt_r : (mcnt_r + 4'd1);

    // Next-state and next-output logic. A rise always wins over a timeout
    // that would fire in the same cycle.
    always_comb begin
        state_nxt_s  = state_r;
        mcnt_nxt_s   = mcnt_r;
        period_nxt_s = period_r;
        high_nxt_s   = high_r;
        valid_nxt_s  = 1'b0;
        err_nxt_s    = 1'b0;
        stall_nxt_s  = 1'b0;
        locked_nxt_s = locked_r;

        case (state_r)
            ST_IDLE: begin
                // First edge only starts a measurement window.
                if (rise_s) begin
                    state_nxt_s  = ST_MEAS;
                    mcnt_nxt_s   = 4'd0;
                    locked_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MEAS, ST_LOCKED: begin
                if (rise_s) begin
                    period_nxt_s = cnt_r;
                    high_nxt_s   = hcnt_r;
                    valid_nxt_s  = 1'b1;
                    if (match_s) begin
                        mcnt_nxt_s = mcnt_inc_s;
                        if (mcnt_inc_s >= LOCK_TGT) begin
                            state_nxt_s  = ST_LOCKED;
                            locked_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_MEAS;
                        end
                    end else begin
                        err_nxt_s    = 1'b1;
                        mcnt_nxt_s   = 4'd0;
                        locked_nxt_s = 1'b0;
                        state_nxt_s  = ST_MEAS;
                    end
                end else if (cnt_r == TIMEOUT) begin
                    // Leaving for IDLE guarantees one stall per loss of clock.
                    stall_nxt_s  = 1'b1;
                    mcnt_nxt_s   = 4'd0;
                    locked_nxt_s = 1'b0;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                mcnt_nxt_s   = 4'd0;
                locked_nxt_s = 1'b0;
            end
        endcase
    end

    // State, match counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            mcnt_r   <= 4'd0;
            period_r <= CNT_ZERO;
            high_r   <= CNT_ZERO;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            stall_r  <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            mcnt_r   <= mcnt_nxt_s;
            period_r <= period_nxt_s;
            high_r   <= high_nxt_s;
            valid_r  <= valid_nxt_s;
            err_r    <= err_nxt_s;
            stall_r  <= stall_nxt_s;
            locked_r <= locked_nxt_s;
        end
    end

    assign o_period     = period_r;
    assign o_high       = high_r;
    assign o_meas_valid = valid_r;
    assign o_err        = err_r;
    assign o_stall      = stall_r;
    assign o_locked     = locked_r;

endmodule

// File: tb/tb_divclk_monitor.sv
// -----------------------------------------------------------------------------
// tb_divclk_monitor
// Directed bench for divclk_monitor. Two instances (direct sampling and with
// synchronizer) watch the same divided clock. Each stimulus step drives one
// i_clk cycle of i_div_clk and records every published measurement and stall
// with its cycle index; the recorded events are compared against hand-derived
// tables afterwards.
// -----------------------------------------------------------------------------
module tb_divclk_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       div_clk = 1'b0;

    logic [7:0] per0, high0, per1, high1;
    logic       v0, e0, s0, l0;
    logic       v1, e1, s1, l1;

    typedef struct {
        int cyc;
        int per;
        int hi;
        int err;
        int lk;
    } ev_t;

    ev_t  q0[$];
    ev_t  q1[$];
    int   st0[$];
    int   st1[$];
    int   cyc = 0;
    int   base = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   anomalies = 0;
    logic pv0 = 1'b0, pe0 = 1'b0, ps0 = 1'b0;
    logic pv1 = 1'b0, pe1 = 1'b0, ps1 = 1'b0;

    always #5 clk = ~clk;

    divclk_monitor #(.P_SYNC(0)) dut0 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_div_clk    (div_clk),
        .o_period     (per0),
        .o_high       (high0),
        .o_meas_valid (v0),
        .o_err        (e0),
        .o_stall      (s0),
        .o_locked     (l0)
    );

    divclk_monitor #(.P_SYNC(1)) dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_div_clk    (div_clk),
        .o_period     (per1),
        .o_high       (high1),
        .o_meas_valid (v1),
        .o_err        (e1),
        .o_stall      (s1),
        .o_locked     (l1)
    );

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // One i_clk cycle of stimulus; outputs are observed 1 ns after the edge.
    task automatic drive(input logic v);
        div_clk = v;
        @(posedge clk);
        #1;
        if (v0) q0.push_back(ev_t'{cyc, int'(per0), int'(high0), int'(e0), int'(l0)});
        if (v1) q1.push_back(ev_t'{cyc, int'(per1), int'(high1), int'(e1), int'(l1)});
        if (s0) st0.push_back(cyc);
        if (s1) st1.push_back(cyc);
        if ((e0 && !v0) || (e1 && !v1)) anomalies++;
        if ((v0 && pv0) || (e0 && pe0) || (s0 && ps0)) anomalies++;
        if ((v1 && pv1) || (e1 && pe1) || (s1 && ps1)) anomalies++;
        pv0 = v0; pe0 = e0; ps0 = s0;
        pv1 = v1; pe1 = e1; ps1 = s1;
        cyc++;
    endtask

    task automatic period(input int hi, input int len);
        for (int i = 0; i < len; i++) drive(i < hi);
    endtask

    task automatic start_phase();
        q0.delete();
        q1.delete();
        st0.delete();
        st1.delete();
        base = cyc;
    endtask

    task automatic chk_ev(input string tag, input int which, input int i, input int off,
                          input int per, input int hi, input int err, input int lk);
        ev_t e;
        int  sz;
        sz = (which == 0) ? q0.size() : q1.size();
        if (i >= sz) begin
            chk($sformatf("%s_ev%0d_missing", tag, i), sz, i + 1);
        end else begin
            if (which == 0) e = q0[i];
            else            e = q1[i];
            chk($sformatf("%s_ev%0d_cyc", tag, i), e.cyc, base + off);
            chk($sformatf("%s_ev%0d_period", tag, i), e.per, per);
            chk($sformatf("%s_ev%0d_high", tag, i), e.hi, hi);
            chk($sformatf("%s_ev%0d_err", tag, i), e.err, err);
            chk($sformatf("%s_ev%0d_locked", tag, i), e.lk, lk);
        end
    endtask

    task automatic chk_zero(input string tag, input int which);
        if (which == 0) begin
            chk({tag, "_period"}, int'(per0), 0);
            chk({tag, "_high"}, int'(high0), 0);
            chk({tag, "_valid"}, int'(v0), 0);
            chk({tag, "_err"}, int'(e0), 0);
            chk({tag, "_stall"}, int'(s0), 0);
            chk({tag, "_locked"}, int'(l0), 0);
        end else begin
            chk({tag, "_period"}, int'(per1), 0);
            chk({tag, "_high"}, int'(high1), 0);
            chk({tag, "_valid"}, int'(v1), 0);
            chk({tag, "_err"}, int'(e1), 0);
            chk({tag, "_stall"}, int'(s1), 0);
            chk({tag, "_locked"}, int'(l1), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        div_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst_s0", 0);
        chk_zero("rst_s1", 1);
        rst_n = 1'b1;

        // Test 1 / 6: nominal clock, period 4 high 2, ten periods.
        start_phase();
        repeat (10) period(2, 4);
        chk("t1_count_s0", q0.size(), 9);
        chk("t1_count_s1", q1.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk_ev("t1", 0, i, 4 * i + 5, 4, 2, 0, (i >= 3) ? 1 : 0);
            chk_ev("t6", 1, i, 4 * i + 7, 4, 2, 0, (i >= 3) ? 1 : 0);
        end
        chk("t1_stalls", st0.size() + st1.size(), 0);

        // Test 2: one long period (5), then relock after four good ones.
        start_phase();
        period(2, 5);
        repeat (6) period(2, 4);
        chk("t2_count", q0.size(), 7);
        chk_ev("t2", 0, 0, 1, 4, 2, 0, 1);
        chk_ev("t2", 0, 1, 6, 5, 2, 1, 0);
        chk_ev("t2", 0, 2, 10, 4, 2, 0, 0);
        chk_ev("t2", 0, 3, 14, 4, 2, 0, 0);
        chk_ev("t2", 0, 4, 18, 4, 2, 0, 0);
        chk_ev("t2", 0, 5, 22, 4, 2, 0, 1);
        chk_ev("t2", 0, 6, 26, 4, 2, 0, 1);

        // Test 3: one period with high time 1.
        start_phase();
        period(1, 4);
        repeat (5) period(2, 4);
        chk("t3_count", q0.size(), 6);
        chk_ev("t3", 0, 0, 1, 4, 2, 0, 1);
        chk_ev("t3", 0, 1, 5, 4, 1, 1, 0);
        chk_ev("t3", 0, 2, 9, 4, 2, 0, 0);
        chk_ev("t3", 0, 5, 21, 4, 2, 0, 1);

        // Test 4: clock stops low, single stall, then relock after 1+4 rises.
        start_phase();
        period(2, 4);
        repeat (30) drive(1'b0);
        chk("t4_stall_count", st0.size(), 1);
        if (st0.size() > 0) chk("t4_stall_cyc", st0[0], base + 17);
        chk("t4_locked_low", int'(l0), 0);
        chk("t4_period_kept", int'(per0), 4);
        chk("t4_high_kept", int'(high0), 2);
        repeat (6) period(2, 4);
        chk("t4_stall_count_end", st0.size(), 1);
        chk("t4_count", q0.size(), 6);
        chk_ev("t4", 0, 0, 1, 4, 2, 0, 1);
        chk_ev("t4", 0, 1, 39, 4, 2, 0, 0);
        chk_ev("t4", 0, 3, 47, 4, 2, 0, 0);
        chk_ev("t4", 0, 4, 51, 4, 2, 0, 1);

        // Test 5: asynchronous reset mid-lock, released with the input high.
        start_phase();
        drive(1'b1);
        drive(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t5_async_s0", 0);
        chk_zero("t5_async_s1", 1);
        repeat (3) drive(1'b1);
        rst_n = 1'b1;
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        repeat (2) period(2, 4);
        chk("t5_count", q0.size(), 3);
        chk_ev("t5", 0, 0, 1, 4, 2, 0, 1);
        chk_ev("t5", 0, 1, 9, 3, 1, 1, 0);
        chk_ev("t5", 0, 2, 13, 4, 2, 0, 0);

        chk("pulse_anomalies", anomalies, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
